// File: rtl/adder_arbiter.sv
// Round-robin scheduler sharing one combinational adder among N requesters.
// Optional output self-check enabled by defining ADDER_ARB_CHECK_EN.
module adder_arbiter #(
    parameter int WIDTH  = 4,
    parameter int N      = 4,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   a_in,
    input  logic [N*WIDTH-1:0]   b_in,
    output logic [N-1:0]         gnt,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    input  logic [WIDTH:0]       add_out,
    output logic                 res_valid,
    output logic [$clog2(N)-1:0] res_id,
    output logic [WIDTH:0]       res_sum,
    output logic                 busy,
    output logic                 err
);

    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(SETTLE + 1);

    typedef enum logic {ST_IDLE, ST_SETTLE} state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [IDW-1:0]   ptr, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   win;
    logic             win_found;
    logic [N-1:0]     gnt_d;
    logic [WIDTH-1:0] add_a_d, add_b_d;
    logic             res_valid_d;
    logic [IDW-1:0]   res_id_d;
    logic [WIDTH:0]   res_sum_d;

    // Rotating priority search: the first requester at or above ptr, wrapping mod N.
    always_comb begin
        int idx;
        win       = '0;
        win_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!win_found && req[idx]) begin
                win       = IDW'(idx);
                win_found = 1'b1;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        ptr_d       = ptr;
        id_d        = id_q;
        add_a_d     = add_a;
        add_b_d     = add_b;
        gnt_d       = '0;
        res_valid_d = 1'b0;
        res_id_d    = res_id;
        res_sum_d   = res_sum;
        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    add_a_d = a_in[win*WIDTH +: WIDTH];
                    add_b_d = b_in[win*WIDTH +: WIDTH];
                    gnt_d   = N'(1) << win;
                    id_d    = win;
                    cnt_d   = CW'(SETTLE);
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt - 1'b1;
                // Sample on the edge where the counter would reach zero.
                if (cnt == CW'(1)) begin
                    res_sum_d   = add_out;
                    res_id_d    = id_q;
                    res_valid_d = 1'b1;
                    ptr_d       = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ptr       <= '0;
            id_q      <= '0;
            gnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_sum   <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ptr       <= ptr_d;
            id_q      <= id_d;
            gnt       <= gnt_d;
            add_a     <= add_a_d;
            add_b     <= add_b_d;
            res_valid <= res_valid_d;
            res_id    <= res_id_d;
            res_sum   <= res_sum_d;
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef ADDER_ARB_CHECK_EN
    logic           sample;
    logic [WIDTH:0] ref_sum;

    assign sample  = (state == ST_SETTLE) && (cnt == CW'(1));
    assign ref_sum = {1'b0, add_a} + {1'b0, add_b};

    // Sticky until reset; never affects the returned result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (sample && (add_out != ref_sum)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: vector table, corner sequences and
// randomized traffic against a transaction-level round-robin model.
module tb_adder_arbiter;

    localparam int W = 4;
    localparam int N = 4;
    localparam int S = 2;
    localparam int IDW = $clog2(N);
`ifdef ADDER_ARB_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   a_in = '0;
    logic [N*W-1:0]   b_in = '0;
    logic [N-1:0]     gnt;
    logic [W-1:0]     add_a, add_b;
    logic [W:0]       add_out;
    logic             res_valid;
    logic [IDW-1:0]   res_id;
    logic [W:0]       res_sum;
    logic             busy;
    logic             err;
    logic             stuck = 1'b0;
    logic             err_exp = 1'b0;

    int checks = 0;
    int errors = 0;

    adder_arbiter #(.WIDTH(W), .N(N), .SETTLE(S)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_out(add_out),
        .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum),
        .busy(busy), .err(err)
    );

    // Shared combinational adder, with an optional stuck-at-zero fault.
    assign add_out = stuck ? '0 : ({1'b0, add_a} + {1'b0, add_b});

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // One full transaction: capture edge, settle, result; requester w drops after gnt.
    task automatic run_txn(input string nm, input logic [N-1:0] r, input logic [N*W-1:0] av,
                           input logic [N*W-1:0] bv, input int w, input logic [W:0] es);
        logic [N-1:0] onehot;
        onehot    = '0;
        onehot[w] = 1'b1;
        req  = r;
        a_in = av;
        b_in = bv;
        step();
        check({nm, ".gnt"}, 64'(gnt), 64'(onehot));
        check({nm, ".busy"}, 64'(busy), 64'd1);
        check({nm, ".add_a"}, 64'(add_a), 64'(av[w*W +: W]));
        check({nm, ".add_b"}, 64'(add_b), 64'(bv[w*W +: W]));
        req = r & ~onehot;
        a_in = ~av;
        b_in = ~bv;
        for (int i = 1; i < S; i++) begin
            step();
            check({nm, ".early_valid"}, 64'(res_valid), 64'd0);
            check({nm, ".gnt_pulse"}, 64'(gnt), 64'd0);
        end
        step();
        check({nm, ".res_valid"}, 64'(res_valid), 64'd1);
        check({nm, ".res_id"}, 64'(res_id), 64'(w));
        check({nm, ".res_sum"}, 64'(res_sum), 64'(es));
        check({nm, ".idle"}, 64'(busy), 64'd0);
        check({nm, ".err"}, 64'(err), 64'(err_exp));
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           id;
        logic [W:0]   sum;
    } vec_t;

    vec_t           vecs[8];
    logic [N*W-1:0] av, bv;
    logic [W-1:0]   lane_a[N];
    logic [W-1:0]   lane_b[N];
    logic [N-1:0]   pending;
    int             ptr_m;
    int             w;

    initial begin
        vecs[0] = '{4'b0001, 4'd9,  4'd8,  0, 5'd17};
        vecs[1] = '{4'b1111, 4'd15, 4'd15, 1, 5'd30};
        vecs[2] = '{4'b1111, 4'd0,  4'd0,  2, 5'd0};
        vecs[3] = '{4'b1001, 4'd7,  4'd3,  3, 5'd10};
        vecs[4] = '{4'b1001, 4'd1,  4'd2,  0, 5'd3};
        vecs[5] = '{4'b1001, 4'd5,  4'd5,  3, 5'd10};
        vecs[6] = '{4'b0110, 4'd15, 4'd1,  1, 5'd16};
        vecs[7] = '{4'b0010, 4'd4,  4'd4,  1, 5'd8};

        // Reset state
        #2;
        check("rst.gnt", 64'(gnt), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.res_valid", 64'(res_valid), 64'd0);
        check("rst.res_sum", 64'(res_sum), 64'd0);
        check("rst.add_a", 64'(add_a), 64'd0);
        check("rst.err", 64'(err), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_noreq.busy", 64'(busy), 64'd0);
        check("idle_noreq.gnt", 64'(gnt), 64'd0);

        // Vector table, applied back to back from ptr=0
        foreach (vecs[i]) begin
            av = N*W'($urandom);
            bv = N*W'($urandom);
            av[vecs[i].id*W +: W] = vecs[i].a;
            bv[vecs[i].id*W +: W] = vecs[i].b;
            run_txn($sformatf("vec%0d", i), vecs[i].req, av, bv, vecs[i].id, vecs[i].sum);
        end

        // Reset mid-SETTLE: operation dropped, held request re-granted from ptr=0
        av = N*W'($urandom);
        bv = N*W'($urandom);
        req  = 4'b1000;
        a_in = av;
        b_in = bv;
        step();
        check("midrst.gnt_before", 64'(gnt), 64'b1000);
        req = 4'b0100;
        rst_n = 1'b0;
        #1;
        check("midrst.gnt", 64'(gnt), 64'd0);
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.add_a", 64'(add_a), 64'd0);
        check("midrst.add_b", 64'(add_b), 64'd0);
        check("midrst.res_sum", 64'(res_sum), 64'd0);
        check("midrst.res_id", 64'(res_id), 64'd0);
        step();
        check("midrst.no_valid", 64'(res_valid), 64'd0);
        rst_n = 1'b1;
        av = N*W'($urandom);
        bv = N*W'($urandom);
        run_txn("midrst.regrant", 4'b0100, av, bv, 2, {1'b0, av[2*W +: W]} + {1'b0, bv[2*W +: W]});

        // All four held continuously: strict rotation 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            av = N*W'($urandom);
            bv = N*W'($urandom);
            run_txn($sformatf("rr%0d", i), 4'b1111, av, bv, i % N,
                    {1'b0, av[(i % N)*W +: W]} + {1'b0, bv[(i % N)*W +: W]});
        end

        // Stuck adder output: err only when the checker is built in
        stuck = 1'b1;
        av = '0;
        bv = '0;
        av[0 +: W] = 4'd3;
        bv[0 +: W] = 4'd4;
        err_exp = EXP_ERR;
        run_txn("stuck", 4'b0001, av, bv, 0, 5'd0);
        stuck = 1'b0;
        run_txn("after_stuck", 4'b0001, av, bv, 0, 5'd7);

        // Randomized traffic vs. transaction-level round-robin model
        do_reset();
        check("rand.err_cleared", 64'(err), 64'd0);
        err_exp = 1'b0;
        pending = '0;
        ptr_m   = 0;
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && ($urandom_range(1) == 1)) begin
                    pending[i] = 1'b1;
                    lane_a[i]  = W'($urandom);
                    lane_b[i]  = W'($urandom);
                end
            end
            if (pending == '0) begin
                w = $urandom_range(N - 1);
                pending[w] = 1'b1;
                lane_a[w]  = W'($urandom);
                lane_b[w]  = W'($urandom);
            end
            w = -1;
            for (int j = 0; j < N; j++) begin
                if (w < 0 && pending[(ptr_m + j) % N]) w = (ptr_m + j) % N;
            end
            av = N*W'($urandom);
            bv = N*W'($urandom);
            for (int i = 0; i < N; i++) begin
                if (pending[i]) begin
                    av[i*W +: W] = lane_a[i];
                    bv[i*W +: W] = lane_b[i];
                end
            end
            run_txn($sformatf("rand%0d", t), pending, av, bv, w,
                    (W+1)'(int'(lane_a[w]) + int'(lane_b[w])));
            pending[w] = 1'b0;
            ptr_m = (w + 1) % N;
        end
        req = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
